binary2onehot_stream: RTL and testbench
=======================================

BINARY2ONEHOT_STREAM -- requirements
Module: binary2onehot_stream

Interface
REQ-001 Parameter WIDTH, default 9: width of the one-hot output; SHALL be >= 2.
REQ-002 Parameter BW, fixed at $clog2(WIDTH): width of the binary input; SHALL NOT be overridden.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 i_binary  input  BW  binary index to decode.
REQ-006 i_valid  input  1  i_binary valid.
REQ-007 i_ready  output  1  block accepts input; SHALL be a register output.
REQ-008 o_onehot  output  WIDTH  decoded one-hot word.
REQ-009 o_error  output  1  word carried an out-of-range index; aligned with o_onehot.
REQ-010 o_valid  output  1  o_onehot/o_error valid.
REQ-011 o_ready  input  1  downstream accepts output.
REQ-012 err_count  output  16  out-of-range index counter; present only per REQ-027.

Function
- REQ-013 Input transfer on i_valid & i_ready; output transfer on o_valid & o_ready.
- REQ-014 Decode: o_onehot bit k SHALL be 1 iff the index equals k, for k in 0..WIDTH-1.
- REQ-015 Indices >= WIDTH (e.g. 9..15 for WIDTH=9) SHALL yield all-zero o_onehot.
- REQ-016 Latency SHALL be exactly 1 cycle: a word accepted at edge N SHALL have o_valid high after edge N when the output stage is empty.
- REQ-017 Buffering SHALL use an output register plus one skid register, with states:
  - EMPTY: no word held.
  - ONE: output register holds a word.
  - TWO: output register and skid register both hold a word.
- REQ-018 Transitions:
  - EMPTY->ONE on input transfer.
  - ONE->TWO on input transfer without output transfer.
  - ONE->EMPTY on output transfer without input transfer.
  - ONE stays ONE on simultaneous input and output transfer.
  - TWO->ONE on output transfer; the skid word moves to the output register.
- REQ-019 i_ready SHALL be high in EMPTY and ONE, and low in TWO.
- REQ-020 Sustained i_valid with o_ready high SHALL give one word per cycle with no bubbles.
- REQ-021 While o_valid & !o_ready, o_onehot and o_error SHALL hold stable.
- REQ-022 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
- REQ-023 i_binary SHALL be ignored when i_valid is low.

Reset
- REQ-024 Asserting reset_n low SHALL immediately force:
  - state EMPTY
  - o_valid=0, o_onehot=0, o_error=0
  - i_ready=0 while reset_n is low
  - err_count=0
- REQ-025 On the first edge after reset_n rises, i_ready SHALL go high.
- REQ-026 Reset mid-transfer SHALL discard all held words; no held word SHALL appear after release.

Configuration
- REQ-027 With macro BINARY2ONEHOT_STREAM_RANGE_CHECK_EN defined:
  - o_error SHALL be 1 for words whose index is >= WIDTH.
  - err_count SHALL increment by 1 on each input transfer of an out-of-range index.
  - err_count SHALL saturate at 0xFFFF.
- REQ-028 With the macro undefined:
  - o_error and err_count SHALL be tied to 0.
  - No range-check logic SHALL be synthesized.
  - Decode SHALL still follow REQ-015.

Verification
- REQ-029 Reset then index stream 0..8 with o_ready=1 -> o_onehot 0x001, 0x002, ... 0x100 on consecutive cycles, each 1 cycle after acceptance; no bubbles.
- REQ-030 Send 3, 5, 7 with o_ready=0 -> i_ready low after two accepts, o_onehot holds 0x008; raise o_ready -> outputs 0x008, 0x020, then index 7 accepted and output as 0x080, in order.
- REQ-031 Macro defined, send 12 -> o_onehot=0x000, o_error=1, err_count=1; 9 and 15 -> err_count=3; index 4 -> o_error=0.
- REQ-032 Macro undefined, send 12 -> o_onehot=0x000, o_error=0, err_count=0.
- REQ-033 Fill to TWO, pulse reset_n low mid-cycle:
  - During reset: o_valid=0 and i_ready=0 immediately.
  - After release: i_ready=1 on the first edge; no stale word output.
- REQ-034 Random i_valid/o_ready, 10000 words -> scoreboard matches order and decode, and o_onehot is stable under backpressure.

Source files
------------

// File: rtl/binary2onehot_stream_if.sv
// Stream bundle for the binary-to-one-hot decoder: binary in, one-hot out.
// Both directions use a valid/ready handshake.
interface binary2onehot_stream_if #(
    parameter int WIDTH = 9
);
    localparam int BW = $clog2(WIDTH);

    logic [BW-1:0]    i_binary;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_onehot;
    logic             o_error;
    logic             o_valid;
    logic             o_ready;

    modport slave (
        input  i_binary, i_valid, o_ready,
        output i_ready, o_onehot, o_error, o_valid
    );

    modport master (
        output i_binary, i_valid, o_ready,
        input  i_ready, o_onehot, o_error, o_valid
    );
endinterface

// File: rtl/binary2onehot_stream.sv
// Streaming binary-to-one-hot decoder, 1-cycle latency, output reg + skid reg.
// Define BINARY2ONEHOT_STREAM_RANGE_CHECK_EN for o_error and err_count.
module binary2onehot_stream #(
    parameter int WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    binary2onehot_stream_if.slave         bus,
    output logic [15:0]                   err_count
);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e           state_q, state_d;
    logic             i_ready_q, i_ready_d;
    logic [WIDTH-1:0] oh_q, oh_d;
    logic [WIDTH-1:0] skid_oh_q, skid_oh_d;
    logic [WIDTH-1:0] dec_oh;
    logic             in_xfer, out_xfer;
    logic             ld_out_in, ld_out_skid, ld_skid;

    // Out-of-range indices match no bit, giving an all-zero word.
    always_comb begin
        dec_oh = '0;
        for (int k = 0; k < WIDTH; k++) begin
            dec_oh[k] = (bus.i_binary == BW'(k));
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_out_in   = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        in_xfer     = bus.i_valid & i_ready_q;
        out_xfer    = (state_q != EMPTY) & bus.o_ready;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    ld_out_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    ld_out_in = 1'b1;
                end else if (in_xfer) begin
                    state_d = TWO;
                    ld_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d     = ONE;
                    ld_out_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        i_ready_d = (state_d != TWO);
    end

    always_comb begin
        oh_d      = oh_q;
        skid_oh_d = skid_oh_q;
        unique case (1'b1)
            ld_out_in:   oh_d = dec_oh;
            ld_out_skid: oh_d = skid_oh_q;
            default: ;
        endcase
        if (ld_skid) skid_oh_d = dec_oh;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            i_ready_q <= 1'b0;
            oh_q      <= '0;
            skid_oh_q <= '0;
        end else begin
            state_q   <= state_d;
            i_ready_q <= i_ready_d;
            oh_q      <= oh_d;
            skid_oh_q <= skid_oh_d;
        end
    end

    assign bus.i_ready  = i_ready_q;
    assign bus.o_valid  = (state_q != EMPTY);
    assign bus.o_onehot = oh_q;

`ifdef BINARY2ONEHOT_STREAM_RANGE_CHECK_EN
    logic        dec_err;
    logic        err_q, err_d;
    logic        skid_err_q, skid_err_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        dec_err    = ~|dec_oh;
        err_d      = err_q;
        skid_err_d = skid_err_q;
        cnt_d      = cnt_q;
        unique case (1'b1)
            ld_out_in:   err_d = dec_err;
            ld_out_skid: err_d = skid_err_q;
            default: ;
        endcase
        if (ld_skid) skid_err_d = dec_err;
        if (in_xfer && dec_err && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q      <= 1'b0;
            skid_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            err_q      <= err_d;
            skid_err_q <= skid_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_error = err_q;
    assign err_count   = cnt_q;
`else
    assign bus.o_error = 1'b0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_binary2onehot_stream.sv
// Directed + random bench for binary2onehot_stream with an in-order scoreboard.
// Error expectations follow BINARY2ONEHOT_STREAM_RANGE_CHECK_EN.
module tb_binary2onehot_stream;
    localparam int W = 9;
    localparam int N = 10000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] err_count;

    binary2onehot_stream_if #(.WIDTH(W)) bus ();

    binary2onehot_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [W:0] sb[$];
    logic [W:0] hold_w;
    logic       hold_v = 1'b0;

    function automatic logic [W:0] model(input logic [3:0] idx);
        logic [W:0] w;
        w = '0;
        if (idx < W) w[idx] = 1'b1;
`ifdef BINARY2ONEHOT_STREAM_RANGE_CHECK_EN
        w[W] = (idx >= W);
`endif
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("valid_held", 32'(bus.o_valid), 1);
            if (bus.o_valid) begin
                if (hold_v) chk("stable", 32'({bus.o_error, bus.o_onehot}), 32'(hold_w));
                if (bus.o_ready) begin
                    chk("sb_nonempty", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0)
                        chk("order", 32'({bus.o_error, bus.o_onehot}), 32'(sb.pop_front()));
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_w = {bus.o_error, bus.o_onehot};
                end
            end else begin
                hold_v = 1'b0;
            end
            if (bus.i_valid && bus.i_ready) sb.push_back(model(bus.i_binary));
        end
    end

    task automatic send_one(input logic [3:0] idx);
        bus.i_binary = idx;
        bus.i_valid  = 1'b1;
        @(posedge clk); #1;
        bus.i_valid  = 1'b0;
    endtask

    initial begin
        int   sent;
        int   cyc;
        logic took;
        logic exp_err;
        bus.i_binary = '0;
        bus.i_valid  = 1'b0;
        bus.o_ready  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_o_valid", 32'(bus.o_valid), 0);
        chk("rst_i_ready", 32'(bus.i_ready), 0);
        chk("rst_onehot", 32'(bus.o_onehot), 0);
        chk("rst_err_count", 32'(err_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(bus.i_ready), 1);

        // Back-to-back stream 0..8
        bus.o_ready = 1'b1;
        for (int k = 0; k < W; k++) begin
            bus.i_binary = 4'(k);
            bus.i_valid  = 1'b1;
            @(posedge clk); #1;
            chk("stream_valid", 32'(bus.o_valid), 1);
            chk("stream_onehot", 32'(bus.o_onehot), 32'(1) << k);
            chk("stream_ready", 32'(bus.i_ready), 1);
        end
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_drain", 32'(bus.o_valid), 0);

        // Backpressure: 3, 5, 7 with o_ready low
        bus.o_ready  = 1'b0;
        bus.i_binary = 4'd3;
        bus.i_valid  = 1'b1;
        @(posedge clk); #1;
        chk("bp_first_oh", 32'(bus.o_onehot), 32'h008);
        chk("bp_first_ready", 32'(bus.i_ready), 1);
        bus.i_binary = 4'd5;
        @(posedge clk); #1;
        chk("bp_full_ready", 32'(bus.i_ready), 0);
        chk("bp_full_oh", 32'(bus.o_onehot), 32'h008);
        bus.i_binary = 4'd7;
        @(posedge clk); #1;
        chk("bp_hold_ready", 32'(bus.i_ready), 0);
        chk("bp_hold_oh", 32'(bus.o_onehot), 32'h008);
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second_oh", 32'(bus.o_onehot), 32'h020);
        chk("bp_reopen_ready", 32'(bus.i_ready), 1);
        @(posedge clk); #1;
        chk("bp_third_oh", 32'(bus.o_onehot), 32'h080);
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain", 32'(bus.o_valid), 0);

        // Out-of-range indices
`ifdef BINARY2ONEHOT_STREAM_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        send_one(4'd12);
        chk("oor_onehot", 32'(bus.o_onehot), 0);
        chk("oor_error", 32'(bus.o_error), 32'(exp_err));
        chk("oor_count1", 32'(err_count), exp_err ? 1 : 0);
        send_one(4'd9);
        send_one(4'd15);
        chk("oor_onehot_15", 32'(bus.o_onehot), 0);
        chk("oor_count3", 32'(err_count), exp_err ? 3 : 0);
        send_one(4'd4);
        chk("inrange_error", 32'(bus.o_error), 0);
        chk("inrange_onehot", 32'(bus.o_onehot), 32'h010);
        @(posedge clk); #1;

        // Reset while both registers are full
        bus.o_ready  = 1'b0;
        bus.i_binary = 4'd3;
        bus.i_valid  = 1'b1;
        @(posedge clk); #1;
        bus.i_binary = 4'd5;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        chk("fill_two_ready", 32'(bus.i_ready), 0);
        #2 reset_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_o_valid", 32'(bus.o_valid), 0);
        chk("midrst_i_ready", 32'(bus.i_ready), 0);
        chk("midrst_onehot", 32'(bus.o_onehot), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.i_ready), 1);
        chk("post_rst_valid", 32'(bus.o_valid), 0);
        @(posedge clk); #1;
        chk("post_rst_stale", 32'(bus.o_valid), 0);

        // Random traffic
        sent = 0;
        cyc  = 0;
        while (sent < N && cyc < 60000) begin
            @(negedge clk);
            took = bus.i_valid && bus.i_ready;
            @(posedge clk); #1;
            cyc++;
            if (took) sent++;
            if (took || !bus.i_valid) begin
                bus.i_valid  = (sent < N) && ($urandom_range(3) != 0);
                bus.i_binary = 4'($urandom_range(15));
            end
            bus.o_ready = ($urandom_range(2) != 0);
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        chk("random_sent", sent, N);
        cyc = 0;
        while ((sb.size() != 0 || bus.o_valid) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk); #1;
        chk("drain_queue", 32'(sb.size()), 0);
        chk("drain_valid", 32'(bus.o_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
